// File: rtl/tube_disp_arbiter_pkg.sv
// Shared types and helpers for the seven-segment display arbiter.
package tube_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  // Bit width needed to hold values 0..value-1. Never returns less than 1,
  // so single-bit fields stay legal for the smallest configurations.
  function automatic int clog2w(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/tube_disp_arbiter_if.sv
// Client/display bus of the arbiter: requests and words in, owner and word out.
interface tube_disp_arbiter_if
  import tube_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);

  localparam int IDX_W = clog2w(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [DATA_W-1:0]         disp_data;
  logic                      disp_en;
  logic [NUM_REQ-1:0]        grant;
  logic [IDX_W-1:0]          grant_idx;
  logic                      grant_start;

  // Client side: drives requests and words, observes ownership.
  modport master (
    output req, req_data,
    input  disp_data, disp_en, grant, grant_idx, grant_start
  );

  // Arbiter side.
  modport slave (
    input  req, req_data,
    output disp_data, disp_en, grant, grant_idx, grant_start
  );

endinterface

// File: rtl/tube_disp_arbiter_rr_pick.sv
// Round-robin winner search: first set request after the pointer, wrapping.
// With i_excl set, the pointer's own slot is skipped entirely so a current
// owner can never re-win against itself.
module tube_rr_pick
  import tube_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  input  logic               i_excl,
  output logic               o_found,
  output logic [IDX_W-1:0]   o_idx
);

  logic [IDX_W-1:0] w_cand;

  // Scan slots ptr+1 .. ptr+NUM_REQ (mod NUM_REQ); the pointer slot is last.
  always_comb begin
    o_found = 1'b0;
    o_idx   = i_ptr;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
      if (!o_found && i_req[w_cand] && !(i_excl && (k == NUM_REQ))) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/tube_disp_arbiter.sv
// Round-robin owner arbitration for the shared 8-digit display driver.
// An owner keeps the display for at least HOLD_CYCLES unless it releases;
// the owner's word is passed through to the driver with one cycle latency.
module tube_disp_arbiter
  import tube_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic                 clk,
  input  logic                 rst,
  tube_disp_arbiter_if.slave   bus
);

  localparam int IDX_W = clog2w(NUM_REQ);
  localparam int CNT_W = clog2w(HOLD_CYCLES);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_RST  = IDX_W'(NUM_REQ - 1);

  arb_state_e          r_state;
  logic [NUM_REQ-1:0]  r_grant;
  logic [IDX_W-1:0]    r_grant_idx;
  logic [DATA_W-1:0]   r_disp_data;
  logic                r_disp_en;
  logic                r_grant_start;
  logic [CNT_W-1:0]    r_hold_cnt;

  arb_state_e          w_state_nxt;
  logic                w_load;
  logic                w_excl;
  logic                w_found;
  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_owner_req;
  logic                w_hold_done;
  logic [IDX_W-1:0]    w_sel_idx;
  logic [DATA_W-1:0]   w_sel_data;

  assign w_owner_req = bus.req[r_grant_idx];
  assign w_hold_done = (r_hold_cnt == HOLD_MAX);
  // While owning, the owner slot is excluded, so w_found means "someone else".
  assign w_excl      = (r_state == OWN);

  tube_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req   (bus.req),
    .i_ptr   (r_grant_idx),
    .i_excl  (w_excl),
    .o_found (w_found),
    .o_idx   (w_pick_idx)
  );

  // Word source for the display: the incoming winner on a new grant,
  // otherwise the current owner.
  assign w_sel_idx  = w_load ? w_pick_idx : r_grant_idx;
  assign w_sel_data = bus.req_data[int'(w_sel_idx)*DATA_W +: DATA_W];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and new-grant decision; release wins over hold timing.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_load      = 1'b1;
          w_state_nxt = OWN;
        end
      end
      OWN: begin
        if (!w_owner_req) begin
          if (w_found) w_load      = 1'b1;
          else         w_state_nxt = IDLE;
        end else if (w_hold_done && w_found) begin
          w_load = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Ownership outputs: grant vector, owner index, enable and start pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant       <= '0;
      r_grant_idx   <= IDX_RST;
      r_disp_en     <= 1'b0;
      r_grant_start <= 1'b0;
    end else begin
      r_grant_start <= w_load;
      if (w_load) begin
        r_grant     <= NUM_REQ'(1) << w_pick_idx;
        r_grant_idx <= w_pick_idx;
        r_disp_en   <= 1'b1;
      end else if (w_state_nxt == IDLE) begin
        r_grant   <= '0;
        r_disp_en <= 1'b0;
      end
    end
  end

  // Display word: live copy of the owner's word; frozen while idle.
  always_ff @(posedge clk) begin
    if (rst)                     r_disp_data <= '0;
    else if (w_state_nxt == OWN) r_disp_data <= w_sel_data;
  end

  // Ownership age; restarts on every grant and saturates at HOLD_MAX.
  always_ff @(posedge clk) begin
    if (rst)                                    r_hold_cnt <= '0;
    else if (w_load)                            r_hold_cnt <= '0;
    else if ((r_state == OWN) && !w_hold_done)  r_hold_cnt <= r_hold_cnt + 1'b1;
  end

  assign bus.grant       = r_grant;
  assign bus.grant_idx   = r_grant_idx;
  assign bus.disp_en     = r_disp_en;
  assign bus.disp_data   = r_disp_data;
  assign bus.grant_start = r_grant_start;

endmodule

// File: tb/tb_tube_disp_arbiter.sv
// Bench for tube_disp_arbiter: fixed vector table, directed corner sequences
// and randomized traffic, all checked against an ownership-level model.
module tb_tube_disp_arbiter;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int HOLD = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [DW-1:0] d [N];

  tube_disp_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

  assign bus.req      = req;
  assign bus.req_data = {d[3], d[2], d[1], d[0]};

  tube_disp_arbiter #(
    .NUM_REQ     (N),
    .DATA_W      (DW),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the display and for how many cycles.
  int          m_owner = -1;   // -1 means nobody
  int          m_last  = N-1;
  int          m_held  = 0;    // cycles of ownership including the grant cycle
  logic [31:0] m_data  = '0;
  logic        m_start = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_req(input logic [N-1:0] r, input int from, input int count);
    for (int j = 0; j < count; j++) begin
      if (r[(from + j) % N]) return (from + j) % N;
    end
    return -1;
  endfunction

  task automatic give(input int w);
    m_owner = w;
    m_last  = w;
    m_held  = 1;
    m_start = 1'b1;
    m_data  = d[w];
  endtask

  task automatic model_step();
    int w;
    if (rst) begin
      m_owner = -1; m_last = N-1; m_held = 0; m_data = '0; m_start = 1'b0;
      return;
    end
    m_start = 1'b0;
    if (m_owner < 0) begin
      w = first_req(req, m_last + 1, N);
      if (w >= 0) give(w);
    end else begin
      // Candidates are the other clients only, starting after the owner.
      w = first_req(req, m_owner + 1, N - 1);
      if (!req[m_owner]) begin
        if (w >= 0) give(w);
        else        m_owner = -1;
      end else if (m_held >= HOLD && w >= 0) begin
        give(w);
      end else begin
        m_held++;
        m_data = d[m_owner];
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("m_grant", 32'(bus.grant), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    chk("m_en",    32'(bus.disp_en), (m_owner < 0) ? 32'd0 : 32'd1);
    chk("m_idx",   32'(bus.grant_idx), 32'(m_last));
    chk("m_start", 32'(bus.grant_start), 32'(m_start));
    chk("m_data",  bus.disp_data, m_data);
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  exp_grant;
    logic        exp_start;
    logic        exp_en;
    logic [31:0] exp_data;
    logic [1:0]  exp_idx;
  } vec_t;

  vec_t tbl [14];

  int starts;
  int gbad;

  initial begin
    rst = 1'b1;
    req = '0;
    d[0] = 32'h01234567; d[1] = 32'h11111111;
    d[2] = 32'hABCDEF01; d[3] = 32'h33333333;

    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h00000000, 2'd3};
    tbl[1]  = '{1'b0, 4'b0101, 4'b0001, 1'b1, 1'b1, 32'h01234567, 2'd0};
    for (int i = 2; i <= 8; i++)
      tbl[i] = '{1'b0, 4'b0101, 4'b0001, 1'b0, 1'b1, 32'h01234567, 2'd0};
    tbl[9]  = '{1'b0, 4'b0101, 4'b0100, 1'b1, 1'b1, 32'hABCDEF01, 2'd2};
    tbl[10] = '{1'b0, 4'b0101, 4'b0100, 1'b0, 1'b1, 32'hABCDEF01, 2'd2};
    tbl[11] = '{1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 32'h01234567, 2'd0};
    tbl[12] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h01234567, 2'd0};
    tbl[13] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h01234567, 2'd0};

    // Reset, then an idle stretch with nobody requesting.
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("idle_grant", 32'(bus.grant), 32'd0);
      chk("idle_en",    32'(bus.disp_en), 32'd0);
      chk("idle_data",  bus.disp_data, 32'd0);
    end

    // Vector table: grant, hold-time preemption, release, idle hold.
    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst;
      req = tbl[i].req;
      cyc();
      chk($sformatf("tbl%0d_grant", i), 32'(bus.grant),       32'(tbl[i].exp_grant));
      chk($sformatf("tbl%0d_start", i), 32'(bus.grant_start), 32'(tbl[i].exp_start));
      chk($sformatf("tbl%0d_en", i),    32'(bus.disp_en),     32'(tbl[i].exp_en));
      chk($sformatf("tbl%0d_data", i),  bus.disp_data,        tbl[i].exp_data);
      chk($sformatf("tbl%0d_idx", i),   32'(bus.grant_idx),   32'(tbl[i].exp_idx));
    end

    // Sole requester keeps the display with a single start pulse.
    rst = 1'b1; req = '0; cyc();
    rst = 1'b0; req = 4'b0010;
    starts = 0; gbad = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (bus.grant_start) starts++;
      if (bus.grant !== 4'b0010) gbad++;
    end
    chk("solo_starts", 32'(starts), 32'd1);
    chk("solo_grant_errs", 32'(gbad), 32'd0);

    // Early release by the owner hands over at once, before hold expires.
    rst = 1'b1; req = '0; cyc();
    rst = 1'b0; req = 4'b1000; cyc();
    chk("c3_grant", 32'(bus.grant), 32'h8);
    req = 4'b1001; cyc(); cyc();
    chk("c3_holds", 32'(bus.grant), 32'h8);
    req = 4'b0001; cyc();
    chk("release_grant", 32'(bus.grant), 32'h1);
    chk("release_start", 32'(bus.grant_start), 32'd1);
    chk("release_en",    32'(bus.disp_en), 32'd1);
    d[0] = 32'h00000001; cyc();
    chk("pass_data1", bus.disp_data, 32'h00000001);
    d[0] = 32'h00000002; cyc();
    chk("pass_data2", bus.disp_data, 32'h00000002);
    req = 4'b0000; cyc();
    chk("drop_grant", 32'(bus.grant), 32'd0);
    chk("drop_en",    32'(bus.disp_en), 32'd0);
    chk("drop_data",  bus.disp_data, 32'h00000002);
    chk("drop_idx",   32'(bus.grant_idx), 32'd0);

    // Reset in the middle of an ownership.
    req = 4'b0001; cyc(); cyc(); cyc();
    chk("pre_rst_grant", 32'(bus.grant), 32'h1);
    rst = 1'b1; cyc();
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_en",    32'(bus.disp_en), 32'd0);
    chk("rst_data",  bus.disp_data, 32'd0);
    chk("rst_idx",   32'(bus.grant_idx), 32'd3);
    chk("rst_start", 32'(bus.grant_start), 32'd0);
    rst = 1'b0; req = 4'b1000; cyc();
    chk("post_rst_grant", 32'(bus.grant), 32'h8);
    chk("post_rst_start", 32'(bus.grant_start), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      if ($urandom_range(0, 1) == 0) d[$urandom_range(0, 3)] = $urandom;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tube_disp_arbiter.md
Name: tube_disp_arbiter

Overview:
Shares the 8-digit seven-segment display driver between up to NUM_REQ client blocks, for example a counter, a clock and a debug monitor.
Each client raises a request and presents 32 bits of hex-nibble data. The block grants one owner at a time using round-robin order. Once an owner is granted, it cannot be preempted until HOLD_CYCLES have elapsed.
The outputs drive the display driver's disp_data/en inputs directly and tell clients who currently owns the display.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
DATA_W, 32, display word width (8 nibbles, digit 0 = bits [3:0]).
HOLD_CYCLES, 50000000, minimum ownership time before preemption (1 s at 50 MHz); must be >= 2.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
req  in  NUM_REQ  per-client display request, level.
req_data  in  NUM_REQ*DATA_W  client words, client i at [i*DATA_W +: DATA_W].
disp_data  out  DATA_W  registered word to the display driver.
disp_en  out  1  scan enable to the display driver; 1 while any owner is granted.
grant  out  NUM_REQ  one-hot current owner, all-zero when idle.
grant_idx  out  clog2(NUM_REQ)  index of current/last owner.
grant_start  out  1  one-cycle pulse on the first cycle of every new grant.

Behaviour:
Clock and reset:
- Single clock domain. Reset is synchronous and active-high; rst has priority over all other logic.
- Reset values: grant=0, grant_idx=NUM_REQ-1 (so client 0 wins first), disp_en=0, disp_data=0, grant_start=0, hold_cnt=0, state=IDLE.

States:
- IDLE: no owner.
  - If any req bit is 1, pick the winner round-robin and go to OWN.
  - On the next edge: grant and grant_idx are set, grant_start=1, disp_en=1, and disp_data takes the winner's req_data value sampled at that edge.
  - Latency from req rising to grant is 1 cycle.
- OWN: disp_data is reloaded every cycle from the owner's req_data, with 1-cycle latency (live pass-through).
  - hold_cnt increments each cycle and saturates at HOLD_CYCLES-1. hold_done = (hold_cnt == HOLD_CYCLES-1).

Re-arbitration triggers (evaluated in OWN):
- Owner's req=0: release immediately, regardless of hold_done.
- hold_done=1 and any other req=1: preempt.
- hold_done=1 and no other requester: the owner keeps the display indefinitely; no re-grant and no grant_start.

Round-robin selection:
- The search starts at grant_idx+1 modulo NUM_REQ and takes the first set req bit.
- The owner's own bit is last in the search order, so the owner only wins if it is the sole requester.

Switching:
- If a winner exists, grant switches on the next edge with no idle gap; disp_en stays 1.
- On a switch, hold_cnt returns to 0, grant_start pulses, and disp_data loads the new owner's word.
- If no winner exists (owner dropped and nobody else requesting), go to IDLE. grant=0 and disp_en=0 on the next edge.
- In IDLE, disp_data and grant_idx hold their last values.

Boundary conditions:
- Simultaneous requests from IDLE: round-robin order from the pointer resolves them.
- Owner drops req in the same cycle hold_done rises: treated as a release, with a single re-arbitration.
- rst asserted mid-grant: on the next edge, all outputs return to their reset values.
- grant is always one-hot or zero.
- hold_cnt width is clog2(HOLD_CYCLES). No wrap is possible because the counter saturates.

Decomposition:
- Package tube_arb_pkg: state enum (IDLE, OWN), plus a shared function for the counter width (clog2).
- One combinational sub-module, tube_rr_pick. Inputs: req, pointer, exclude-owner flag. Outputs: found, winner index. The top level instantiates it once.

Test Plan:
- Reset, then req=4'b0000 for 20 cycles -> grant=0, disp_en=0, disp_data=0.
- With HOLD_CYCLES=8: req=4'b0101, req_data0=32'h01234567, req_data2=32'hABCDEF01 -> cycle+1 grant=0001, grant_start=1, disp_data=32'h01234567; after 8 cycles of ownership, grant=0100, disp_data=32'hABCDEF01, disp_en stays 1.
- Only client 1 requesting for 30 cycles -> grant=0010 throughout, exactly one grant_start pulse.
- Client 3 owns, drops req at cycle 3 of hold, client 0 requesting -> next edge grant=0001; then client 0 drops with no other requester -> IDLE, disp_en=0, disp_data holds 32'h… of client 0.
- While owning, change req_data0 from 32'h00000001 to 32'h00000002 -> disp_data follows 1 cycle later.
- rst=1 asserted mid-OWN for 1 cycle -> next edge all outputs at reset values; after release with req=4'b1000, client 3 is granted.
